// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared CPU definitions for the iterative multiply/divide sequencer:
// the state encoding and the default iteration counts.
package muldiv_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_WB   = 2'd3
    } muldiv_state_e;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Steps the external HI/LO multiply/divide datapath through init, iterate and
// write-back, and raises a stall while HI/LO or the datapath are in use.
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op_div,
    input  logic op_signed,
    input  logic div_zero,
    input  logic hilo_read_id,
    input  logic hilo_write_ex,
    output logic dp_init,
    output logic dp_step,
    output logic dp_op_div,
    output logic dp_signed,
    output logic dp_div0,
    output logic hilo_we,
    output logic busy,
    output logic muldiv_stall
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dp_init_q, dp_init_d;
    logic             dp_step_q, dp_step_d;
    logic             dp_op_div_q, dp_op_div_d;
    logic             dp_signed_q, dp_signed_d;
    logic             dp_div0_q, dp_div0_d;
    logic             hilo_we_q, hilo_we_d;
    logic             busy_q, busy_d;

    // Operand flags are latched only on acceptance in IDLE; a start that
    // arrives while busy is the stalled pipeline re-presenting itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_op_div_d = dp_op_div_q;
        dp_signed_d = dp_signed_q;
        dp_div0_d   = dp_div0_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    dp_op_div_d = op_div;
                    dp_signed_d = op_signed;
                    dp_div0_d   = div_zero & op_div;
                end
            end
            ST_INIT: begin
                cnt_d   = dp_op_div_q ? DIV_LOAD : MUL_LOAD;
                state_d = dp_div0_q ? ST_WB : ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dp_init_d = (state_d == ST_INIT);
        dp_step_d = (state_d == ST_RUN);
        hilo_we_d = (state_d == ST_WB);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dp_init_q   <= 1'b0;
            dp_step_q   <= 1'b0;
            dp_op_div_q <= 1'b0;
            dp_signed_q <= 1'b0;
            dp_div0_q   <= 1'b0;
            hilo_we_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dp_init_q   <= dp_init_d;
            dp_step_q   <= dp_step_d;
            dp_op_div_q <= dp_op_div_d;
            dp_signed_q <= dp_signed_d;
            dp_div0_q   <= dp_div0_d;
            hilo_we_q   <= hilo_we_d;
            busy_q      <= busy_d;
        end
    end

    assign dp_init      = dp_init_q;
    assign dp_step      = dp_step_q;
    assign dp_op_div    = dp_op_div_q;
    assign dp_signed    = dp_signed_q;
    assign dp_div0      = dp_div0_q;
    assign hilo_we      = hilo_we_q;
    assign busy         = busy_q;
    assign muldiv_stall = (state_q != ST_IDLE) & (hilo_read_id | hilo_write_ex | start);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Randomised bench for muldiv_seq_ctrl: a cycle-level busy-window model plus a
// scoreboard that matches each write-back against the operation that caused it.
module tb_muldiv_seq_ctrl;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic op_div = 1'b0;
    logic op_signed = 1'b0;
    logic div_zero = 1'b0;
    logic hilo_read_id = 1'b0;
    logic hilo_write_ex = 1'b0;
    logic dp_init, dp_step, dp_op_div, dp_signed, dp_div0, hilo_we, busy, muldiv_stall;

    always #5 clk = ~clk;

    muldiv_seq_ctrl #(
        .MUL_CYCLES(MULC),
        .DIV_CYCLES(DIVC),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op_div(op_div),
        .op_signed(op_signed),
        .div_zero(div_zero),
        .hilo_read_id(hilo_read_id),
        .hilo_write_ex(hilo_write_ex),
        .dp_init(dp_init),
        .dp_step(dp_step),
        .dp_op_div(dp_op_div),
        .dp_signed(dp_signed),
        .dp_div0(dp_div0),
        .hilo_we(hilo_we),
        .busy(busy),
        .muldiv_stall(muldiv_stall)
    );

    typedef struct {
        bit op_div;
        bit sgn;
        bit div0;
        int steps;
    } op_t;

    op_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;

    // Model: an accepted op keeps the block busy for cur_len cycles.
    int  busy_left = 0;
    int  cur_len = 0;
    bit  m_op_div = 0;
    bit  m_sgn = 0;
    bit  m_div0 = 0;
    bit  checks_on = 0;

    function automatic void check1(input string name, input logic act, input logic expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    endfunction

    function automatic void checkInt(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endfunction

    task automatic checkOutput();
        bit busy_m;
        int k;
        busy_m = (busy_left > 0);
        k = cur_len - busy_left + 1;
        check1("busy", busy, busy_m);
        check1("dp_init", dp_init, busy_m && k == 1);
        check1("dp_step", dp_step, busy_m && k > 1 && busy_left > 1);
        check1("hilo_we", hilo_we, busy_m && busy_left == 1);
        check1("dp_op_div", dp_op_div, m_op_div);
        check1("dp_signed", dp_signed, m_sgn);
        check1("dp_div0", dp_div0, m_div0);
        check1("muldiv_stall", muldiv_stall, busy_m && (hilo_read_id || hilo_write_ex || start));
    endtask

    task automatic modelStep();
        int iters;
        if (reset) begin
            busy_left = 0;
            m_op_div = 0;
            m_sgn = 0;
            m_div0 = 0;
            exp_q.delete();
            checks_on = 1;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (start) begin
            m_op_div = op_div;
            m_sgn = op_signed;
            m_div0 = div_zero && op_div;
            iters = m_div0 ? 0 : (op_div ? DIVC : MULC);
            cur_len = iters + 2;
            busy_left = cur_len;
            exp_q.push_back('{op_div: op_div, sgn: op_signed, div0: m_div0, steps: iters});
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input bit od, input bit sg,
                                 input bit dz, input bit rd, input bit wr);
        reset = rst;
        start = st;
        op_div = od;
        op_signed = sg;
        div_zero = dz;
        hilo_read_id = rd;
        hilo_write_ex = wr;
        @(negedge clk);
        if (checks_on) checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && busy_left > 0; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor: counts steps between init and write-back and pops
    // the matching expected operation on every hilo_we.
    bit  inflight = 0;
    int  steps_seen = 0;
    int  t0 = 0;
    int  mcyc = 0;
    op_t e;

    always @(negedge clk) begin
        if (checks_on) begin
            if (reset) begin
                inflight = 0;
            end else begin
                if (dp_init === 1'b1) begin
                    check1("init_while_inflight", inflight, 1'b0);
                    inflight = 1;
                    steps_seen = 0;
                    t0 = mcyc;
                end
                if (dp_step === 1'b1) steps_seen++;
                if (hilo_we === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL sb_unexpected_we: got hilo_we=1 expected no pending op at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkInt("sb_steps", steps_seen, e.steps);
                        checkInt("sb_latency", mcyc - t0, e.steps + 1);
                        check1("sb_op_div", dp_op_div, e.op_div);
                        check1("sb_signed", dp_signed, e.sgn);
                        check1("sb_div0", dp_div0, e.div0);
                    end
                    inflight = 0;
                end
            end
        end
        mcyc++;
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // multiply, signed divide, divide by zero
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        waitIdle();
        applyStimulus(0, 1, 1, 1, 0, 0, 0);
        waitIdle();
        applyStimulus(0, 1, 1, 0, 1, 0, 0);
        waitIdle();

        // mfhi held and a divide re-presented while a multiply runs
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int c = 3; c <= 7; c++) applyStimulus(0, 1, 1, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        waitIdle();

        // reset in the tenth RUN cycle of a divide
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 10; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                          1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end
        waitIdle();
        checkInt("sb_pending_at_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Sequences the iterative multiply/divide datapath that writes HI/LO.
- Accepts a start pulse from the EX stage and steps the external datapath through init, iterate and write-back phases.
- Drives a stall request that the hazard unit ORs with the load-use stall: PC hold, IF/ID hold and ID/EX bubble.
- Resolves structural hazards (new mult/div or mthi/mtlo while busy) and data hazards on HI/LO (mfhi/mflo while busy).

Parameters:
- MUL_CYCLES, 4, number of RUN iterations for multiply (≥1).
- DIV_CYCLES, 32, number of RUN iterations for divide (≥1).
- CNT_W, 6, iteration counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  mult/multu/div/divu valid in EX and not flushed this cycle.
- op_div  in  1  1 = divide, 0 = multiply; sampled with start.
- op_signed  in  1  signed variant; sampled with start.
- div_zero  in  1  divisor == 0; sampled with start; ignored when op_div=0.
- hilo_read_id  in  1  mfhi/mflo in ID.
- hilo_write_ex  in  1  mthi/mtlo in EX.
- dp_init  out  1  load operands into datapath registers.
- dp_step  out  1  perform one iteration.
- dp_op_div  out  1  latched op_div.
- dp_signed  out  1  latched op_signed.
- dp_div0  out  1  latched div_zero & op_div; datapath writes HI=dividend, LO=all ones.
- hilo_we  out  1  write datapath result to HI/LO this cycle.
- busy  out  1  state != IDLE.
- muldiv_stall  out  1  stall request to hazard unit.

Behaviour:
- All outputs are registered, except muldiv_stall, which is combinational from state and inputs.
- Reset, at the clock edge: state=IDLE, counter=0, and all outputs 0, including the latched dp_op_div, dp_signed and dp_div0.

FSM:
- IDLE: start=1 → INIT; latch op_div, op_signed and div_zero&op_div. start=0 → stay.
- INIT (1 cycle): dp_init=1. Load counter with (op_div ? DIV_CYCLES : MUL_CYCLES)-1. Next state is WB if dp_div0, otherwise RUN.
- RUN: dp_step=1 each cycle. Counter decrements. When counter==0 this cycle → WB.
- WB (1 cycle): hilo_we=1 → IDLE.

Latency and timing:
- Start accepted at edge 0; INIT occupies cycle 1.
- RUN occupies cycles 2..N+1; WB occupies cycle N+2; busy drops in cycle N+3.
- The div0 path is INIT then WB (busy for 2 cycles).

Stall rule:
- muldiv_stall = busy & (hilo_read_id | hilo_write_ex | start).
- The stall holds the offending instruction upstream until the cycle after WB; it then proceeds and sees the updated HI/LO.
- start while busy is ignored by the FSM (no relatch). It is re-presented by the stalled pipeline and accepted in the first IDLE cycle.
- start in IDLE never stalls. mfhi/mflo in IDLE never stall.

Simultaneous events and flush:
- Reset has priority over everything.
- Reset mid-operation aborts immediately: no hilo_we, back to IDLE next cycle.
- Flush of a younger instruction does not abort an accepted operation; it has already committed past EX.
- Counter arithmetic is unsigned CNT_W. No wrap is reachable because exit occurs at 0.

Decomposition:
- Shared CPU package holds:
  - state encoding constants ST_IDLE=2'd0, ST_INIT=2'd1, ST_RUN=2'd2, ST_WB=2'd3;
  - the MUL_CYCLES/DIV_CYCLES defaults.
- No sub-module; the counter stays inline.
- The hazard unit adds muldiv_stall into its PC_holdon/IFID_holdon/IDEX_Flush terms. That is an integration change, not part of this block.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0 and busy=0 for the first cycle after release.
- start, op_div=0, MUL_CYCLES=4 → dp_init high in cycle 1, dp_step high in cycles 2–5, hilo_we high in cycle 6, busy low in cycle 7, dp_op_div=0.
- start, op_div=1, op_signed=1, DIV_CYCLES=32 → exactly 32 dp_step pulses, hilo_we in cycle 34, dp_signed=1 throughout.
- start, op_div=1, div_zero=1 → INIT in cycle 1, hilo_we with dp_div0=1 in cycle 2, zero dp_step pulses.
- Mult in flight with hilo_read_id=1 in cycle 3 and held high → muldiv_stall=1 in cycles 3–6, 0 in cycle 7. A second start while busy produces no relatch, is accepted in cycle 7, and a new INIT follows in cycle 8.
- Reset asserted in RUN cycle 10 of a divide → next cycle state IDLE, busy=0, and hilo_we never asserted.
